robots_reset_heartbeat: RTL and testbench

// Parametrised reset sequencer plus multi-channel LED pattern generator for the robots game top level.

---
 rtl/robots_reset_heartbeat.sv | 109 ++++++++++
 tb/tb_robots_reset_heartbeat.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/robots_reset_heartbeat.sv
// robots_reset_heartbeat: stretched system reset plus NCH rotating-pattern status LEDs.
// Optional per-channel PWM brightness when FPGA_ROBOTS_LED_PWM_EN is defined.
`timescale 1ns/1ps
module robots_reset_heartbeat #(
    parameter int          NCH         = 2,
    parameter int          PAT_W       = 16,
    parameter int          PRESCALE_W  = 22,
    parameter int          RST_STRETCH = 15,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] DEF_PAT0    = 32'h0011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    input  logic             btn_raw,
    input  logic [NCH-1:0]   pat_ld,
    input  logic [PAT_W-1:0] pat_data,
`ifdef FPGA_ROBOTS_LED_PWM_EN
    input  logic [4*NCH-1:0] bright,
`endif
    output logic             sys_rst_o,
    output logic             tick_o,
    output logic [NCH-1:0]   led_o
);
    localparam int PW = $clog2(PAT_W);
    localparam logic [PW-1:0] LAST = PW'(PAT_W - 1);
    localparam logic [PW:0] PAT_N = (PW+1)'(PAT_W);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [7:0]             cnt_q;
    logic                   rst_q;
    logic [PRESCALE_W-1:0]  presc_q;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [PAT_W-1:0]       pat_q [NCH];
    logic [PW-1:0]          off_q [NCH];
    logic [PW-1:0]          slot  [NCH];
    logic                   tick_q;
    logic [NCH-1:0]         led_q, led_d;
    logic                   sys_rst, tick_ev, btn_sync;

    assign btn_sync  = sync_q[SYNC_STAGES-1];
    assign sys_rst   = rst_q | ~locked;
    assign tick_ev   = &presc_q;
    assign sys_rst_o = sys_rst;
    assign tick_o    = tick_q;
    assign led_o     = led_q;

    // Each channel's slot is the shared pointer minus its load-time offset, modulo PAT_W.
    always_comb begin
        ptr_d = tick_ev ? (ptr_q == LAST ? '0 : ptr_q + 1'b1) : ptr_q;
        led_d = '0;
        for (int i = 0; i < NCH; i++) begin
            slot[i] = ptr_q >= off_q[i] ? ptr_q - off_q[i]
                                        : PW'({1'b0, ptr_q} + PAT_N - {1'b0, off_q[i]});
`ifdef FPGA_ROBOTS_LED_PWM_EN
            led_d[i] = pat_q[i][slot[i]] &
                       (bright[4*i +: 4] == 4'hF || presc_q[3:0] < bright[4*i +: 4]);
`else
            led_d[i] = pat_q[i][slot[i]];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            rst_q   <= 1'b1;
            presc_q <= '0;
            ptr_q   <= '0;
            tick_q  <= 1'b0;
            led_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                pat_q[i] <= i == 0 ? DEF_PAT0[PAT_W-1:0] : '0;
                off_q[i] <= '0;
            end
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            if (btn_sync || !locked) begin
                cnt_q <= '0;
                rst_q <= 1'b1;
            end else if (cnt_q != 8'(RST_STRETCH)) begin
                cnt_q <= cnt_q + 8'd1;
                rst_q <= 1'b1;
            end else begin
                rst_q <= 1'b0;
            end
            // Reset realigns every channel to slot 0; pattern contents survive.
            if (sys_rst) begin
                presc_q <= '0;
                ptr_q   <= '0;
                tick_q  <= 1'b0;
                led_q   <= '0;
                for (int i = 0; i < NCH; i++) off_q[i] <= '0;
            end else begin
                presc_q <= presc_q + 1'b1;
                ptr_q   <= ptr_d;
                tick_q  <= tick_ev;
                led_q   <= led_d;
                for (int i = 0; i < NCH; i++) begin
                    if (pat_ld[i]) begin
                        pat_q[i] <= pat_data;
                        off_q[i] <= ptr_d;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_robots_reset_heartbeat.sv
// tb_robots_reset_heartbeat: cycle model pushes expected outputs per edge, tests pop and compare.
`timescale 1ns/1ps
module tb_robots_reset_heartbeat;
    localparam int NCH = 2, PAT_W = 16, RST_STRETCH = 15, SYNC_STAGES = 2;
    typedef struct packed { logic sys; logic tick; logic [NCH-1:0] led; } exp_t;

    logic clk = 1'b0, rst = 1'b1, locked = 1'b1, btn_raw = 1'b0;
    logic [NCH-1:0] pat_ld = '0;
    logic [PAT_W-1:0] pat_data = '0;
    logic [4*NCH-1:0] bright = '1;
    logic sys_rst_o, tick_o;
    logic [NCH-1:0] led_o;

    exp_t sb[$];
    exp_t e;
    int n_cmp = 0, n_bad = 0;

    logic [SYNC_STAGES-1:0] m_sync;
    int m_cnt, m_presc;
    int m_slot [NCH];
    logic [PAT_W-1:0] m_pat [NCH];
    logic m_rstq, m_tick;
    logic [NCH-1:0] m_led;

    always #5 clk = ~clk;

    robots_reset_heartbeat #(.NCH(NCH), .PAT_W(PAT_W), .PRESCALE_W(4), .RST_STRETCH(RST_STRETCH),
                             .SYNC_STAGES(SYNC_STAGES), .DEF_PAT0(32'h0011)) dut (
        .clk(clk), .rst(rst), .locked(locked), .btn_raw(btn_raw), .pat_ld(pat_ld), .pat_data(pat_data),
`ifdef FPGA_ROBOTS_LED_PWM_EN
        .bright(bright),
`endif
        .sys_rst_o(sys_rst_o), .tick_o(tick_o), .led_o(led_o));

    task automatic step();
        logic sys, btn_s, ev, on;
        sys = m_rstq | ~locked;
        btn_s = m_sync[SYNC_STAGES-1];
        if (rst) begin
            m_sync = '1; m_cnt = 0; m_rstq = 1'b1; m_presc = 0; m_tick = 1'b0; m_led = '0;
            for (int i = 0; i < NCH; i++) begin
                m_slot[i] = 0;
                m_pat[i] = i == 0 ? 16'h0011 : 16'h0000;
            end
        end else begin
            m_sync = {m_sync[SYNC_STAGES-2:0], btn_raw};
            if (btn_s || !locked) begin m_cnt = 0; m_rstq = 1'b1; end
            else if (m_cnt != RST_STRETCH) begin m_cnt++; m_rstq = 1'b1; end
            else m_rstq = 1'b0;
            if (sys) begin
                m_presc = 0; m_tick = 1'b0; m_led = '0;
                for (int i = 0; i < NCH; i++) m_slot[i] = 0;
            end else begin
                ev = m_presc == 15;
                for (int i = 0; i < NCH; i++) begin
                    on = m_pat[i][m_slot[i]];
`ifdef FPGA_ROBOTS_LED_PWM_EN
                    on = on & (bright[4*i +: 4] == 4'hF || m_presc < int'(bright[4*i +: 4]));
`endif
                    m_led[i] = on;
                    if (pat_ld[i]) begin m_pat[i] = pat_data; m_slot[i] = 0; end
                    else if (ev) m_slot[i] = (m_slot[i] + 1) % PAT_W;
                end
                m_tick = ev;
                m_presc = (m_presc + 1) % 16;
            end
        end
        sb.push_back({m_rstq | ~locked, m_tick, m_led});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); e = sb.pop_front(); n_cmp++;
            if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL reset_hold k=%0d got %b want %b", k, {sys_rst_o, tick_o, led_o}, e); end
        end
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(); e = sb.pop_front(); n_cmp++;
            if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL reset_release k=%0d got %b want %b", k, {sys_rst_o, tick_o, led_o}, e); end
            n_cmp++;
            if (sys_rst_o !== (k < 18)) begin n_bad++; $display("FAIL reset_edges k=%0d got sys_rst_o=%b want %b", k, sys_rst_o, k < 18); end
        end
    endtask

    task automatic test_button();
        int k, hi;
        for (int j = 0; j < 20; j++) begin
            step(); e = sb.pop_front(); n_cmp++;
            if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL btn_idle got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
        end
        btn_raw = 1'b1;
        step(); e = sb.pop_front(); n_cmp++;
        if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL btn_press got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
        btn_raw = 1'b0;
        k = 1;
        while (sys_rst_o !== 1'b1 && k < 10) begin
            step(); e = sb.pop_front(); n_cmp++; k++;
            if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL btn_rise got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
        end
        n_cmp++;
        if (k !== 3) begin n_bad++; $display("FAIL btn_latency got %0d edges want 3", k); end
        hi = 1;
        for (int j = 0; j < 30; j++) begin
            step(); e = sb.pop_front(); n_cmp++;
            if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL btn_stretch got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
            hi += int'(sys_rst_o === 1'b1);
        end
        n_cmp++;
        if (hi !== 16) begin n_bad++; $display("FAIL btn_high_len got %0d want 16", hi); end
    endtask

    task automatic test_lock();
        int hi;
        for (int j = 0; j < 20; j++) begin
            step(); e = sb.pop_front(); n_cmp++;
            if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL lock_idle got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
        end
        locked = 1'b0;
        #1;
        n_cmp++;
        if (sys_rst_o !== 1'b1) begin n_bad++; $display("FAIL lock_comb got %b want 1", sys_rst_o); end
        step(); e = sb.pop_front(); n_cmp++;
        if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL lock_low got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
        locked = 1'b1;
        hi = 1;
        for (int j = 0; j < 25; j++) begin
            step(); e = sb.pop_front(); n_cmp++;
            if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL lock_stretch got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
            hi += int'(sys_rst_o === 1'b1);
        end
        n_cmp++;
        if (hi !== 16) begin n_bad++; $display("FAIL lock_high_len got %0d want 16", hi); end
    endtask

    task automatic test_pattern();
        int on0, ticks;
        on0 = 0; ticks = 0;
        for (int j = 0; j < 276; j++) begin
            step(); e = sb.pop_front(); n_cmp++;
            if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL pattern j=%0d got %b want %b", j, {sys_rst_o, tick_o, led_o}, e); end
            if (j >= 20) begin on0 += int'(led_o[0] === 1'b1); ticks += int'(tick_o === 1'b1); end
        end
        n_cmp++;
        if (on0 !== 32) begin n_bad++; $display("FAIL pattern_duty got %0d want 32", on0); end
        n_cmp++;
        if (ticks !== 16) begin n_bad++; $display("FAIL tick_count got %0d want 16", ticks); end
    endtask

    task automatic test_load();
        int k;
        k = 0;
        while (tick_o !== 1'b1 && k < 40) begin
            step(); e = sb.pop_front(); n_cmp++; k++;
            if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL load_wait got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
        end
        n_cmp++;
        if (k >= 40) begin n_bad++; $display("FAIL load_tick_timeout got %0d want <40", k); end
        pat_ld = 2'b10; pat_data = 16'hFFFF;
        step(); e = sb.pop_front(); n_cmp++;
        if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL load_edge got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
        pat_ld = '0; pat_data = '0;
        for (int j = 0; j < 64; j++) begin
            step(); e = sb.pop_front(); n_cmp++;
            if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL load_run got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
            n_cmp++;
            if (led_o[1] !== 1'b1) begin n_bad++; $display("FAIL load_ch1_on got %b want 1", led_o[1]); end
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 40; j++) begin
            pat_ld = 2'($urandom_range(0, 3)); pat_data = 16'($urandom);
            step(); e = sb.pop_front(); n_cmp++;
            if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL b2b_load got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
        end
        pat_ld = '0;
        for (int j = 0; j < 300; j++) begin
            step(); e = sb.pop_front(); n_cmp++;
            if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL b2b_run got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
        end
    endtask

`ifdef FPGA_ROBOTS_LED_PWM_EN
    task automatic test_pwm();
        int on0;
        pat_ld = 2'b11; pat_data = 16'hFFFF; bright = {4'h0, 4'h4};
        step(); e = sb.pop_front(); n_cmp++;
        if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL pwm_load got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
        pat_ld = '0;
        on0 = 0;
        for (int j = 0; j < 68; j++) begin
            step(); e = sb.pop_front(); n_cmp++;
            if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL pwm_run got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
            if (j >= 4) on0 += int'(led_o[0] === 1'b1);
        end
        n_cmp++;
        if (on0 !== 16) begin n_bad++; $display("FAIL pwm_duty got %0d want 16", on0); end
        bright = {4'hF, 4'h0};
        for (int j = 0; j < 34; j++) begin
            step(); e = sb.pop_front(); n_cmp++;
            if ({sys_rst_o, tick_o, led_o} !== e) begin n_bad++; $display("FAIL pwm_ends got %b want %b", {sys_rst_o, tick_o, led_o}, e); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_button();
        test_lock();
        test_pattern();
        test_load();
        test_back_to_back();
`ifdef FPGA_ROBOTS_LED_PWM_EN
        test_pwm();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
